// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, pixel fetch strobes and a
// PIX_LAT-aligned output stage that selects external pixels, colour bars or a solid colour.
module video_timing_gen #(
  parameter int H_SYNC  = 136,
  parameter int H_BP    = 160,
  parameter int H_ACT   = 1024,
  parameter int H_FP    = 24,
  parameter int V_SYNC  = 6,
  parameter int V_BP    = 29,
  parameter int V_ACT   = 768,
  parameter int V_FP    = 3,
  parameter int HS_POL  = 1,
  parameter int VS_POL  = 1,
  parameter int PIX_LAT = 2,
  parameter int CW      = 12
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  input  logic [23:0]   rgb_pixel,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic [7:0]    po_vga_r,
  output logic [7:0]    po_vga_g,
  output logic [7:0]    po_vga_b,
  output logic          po_de,
  output logic          po_h_sync,
  output logic          po_v_sync
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int BW      = CW + 3;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SEND   = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SEND   = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ASTART = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_AEND   = CW'(H_SYNC + H_BP + H_ACT);
  localparam logic [CW-1:0] V_ASTART = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_AEND   = CW'(V_SYNC + V_BP + V_ACT);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic [1:0]    r_mode;
  logic [23:0]   r_solid;

  logic          w_run;
  logic          w_frame_start;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic [CW-1:0] w_hoff;
  logic [CW-1:0] w_voff;
  logic [2:0]    w_bar;
  logic [23:0]   w_bar_rgb;
  logic [23:0]   w_int_rgb;
  logic          w_ext;

  // Delay lines; index 0 is the pix_req stage, index PIX_LAT feeds the output register.
  logic          r_de_pipe  [0:PIX_LAT];
  logic          r_hs_pipe  [0:PIX_LAT];
  logic          r_vs_pipe  [0:PIX_LAT];
  logic          r_ext_pipe [0:PIX_LAT];
  logic [23:0]   r_rgb_pipe [0:PIX_LAT];

  assign w_run         = en & ~rst;
  assign w_frame_start = w_run & (r_hcnt == '0) & (r_vcnt == '0);
  assign frame_start   = w_frame_start;
  assign pix_req       = r_de_pipe[0];

  assign w_active = (r_hcnt >= H_ASTART) && (r_hcnt < H_AEND) &&
                    (r_vcnt >= V_ASTART) && (r_vcnt < V_AEND);
  assign w_hs     = (r_hcnt < H_SEND);
  assign w_vs     = (r_vcnt < V_SEND);
  assign w_hoff   = r_hcnt - H_ASTART;
  assign w_voff   = r_vcnt - V_ASTART;
  assign w_bar    = 3'((BW'(w_hoff) << 3) / BW'(H_ACT));

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  // Mode 3 falls through to the solid colour.
  assign w_ext     = (r_mode == 2'd0);
  assign w_int_rgb = (r_mode == 2'd1) ? w_bar_rgb : r_solid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sclk) begin
    if (!w_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Mode and colour change only on a frame boundary, so a frame never tears.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_mode  <= '0;
      r_solid <= '0;
    end else if (w_frame_start) begin
      r_mode  <= mode;
      r_solid <= solid_rgb;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst || !(w_run && w_active)) begin
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      pix_x <= w_hoff;
      pix_y <= w_voff;
    end
  end

  // NOTE: the delay-line arrays are reset in full, so syncs come out inactive and de low straight after reset.
  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int k = 0; k <= PIX_LAT; k++) begin
        r_de_pipe[k]  <= 1'b0;
        r_hs_pipe[k]  <= 1'b0;
        r_vs_pipe[k]  <= 1'b0;
        r_ext_pipe[k] <= 1'b0;
        r_rgb_pipe[k] <= '0;
      end
    end else begin
      r_de_pipe[0]  <= w_run & w_active;
      r_hs_pipe[0]  <= w_run & w_hs;
      r_vs_pipe[0]  <= w_run & w_vs;
      r_ext_pipe[0] <= w_ext;
      r_rgb_pipe[0] <= w_int_rgb;
      for (int k = 1; k <= PIX_LAT; k++) begin
        r_de_pipe[k]  <= r_de_pipe[k-1];
        r_hs_pipe[k]  <= r_hs_pipe[k-1];
        r_vs_pipe[k]  <= r_vs_pipe[k-1];
        r_ext_pipe[k] <= r_ext_pipe[k-1];
        r_rgb_pipe[k] <= r_rgb_pipe[k-1];
      end
    end
  end

  // Output register: the external pixel arrives exactly when its request reaches stage PIX_LAT.
  always_ff @(posedge sclk) begin
    if (rst) begin
      po_de     <= 1'b0;
      po_h_sync <= ~HS_ACT;
      po_v_sync <= ~VS_ACT;
      po_vga_r  <= '0;
      po_vga_g  <= '0;
      po_vga_b  <= '0;
    end else begin
      po_de     <= r_de_pipe[PIX_LAT];
      po_h_sync <= r_hs_pipe[PIX_LAT] ~^ HS_ACT;
      po_v_sync <= r_vs_pipe[PIX_LAT] ~^ VS_ACT;
      if (r_de_pipe[PIX_LAT]) begin
        {po_vga_r, po_vga_g, po_vga_b} <= r_ext_pipe[PIX_LAT] ? rgb_pixel : r_rgb_pipe[PIX_LAT];
      end else begin
        {po_vga_r, po_vga_g, po_vga_b} <= 24'h000000;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench: three configurations share one stimulus stream and are each compared
// cycle by cycle against a raster-position model derived from the timing rules.
module tb_video_timing_gen;

  typedef struct packed {
    logic        req;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  mode;
    logic [23:0] solid;
  } rec_t;

  localparam int NCYC_A = 15000;
  localparam int NCYC_B = 15000;

  logic        sclk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [23:0] noise;
  logic [7:0]  salt;
  bit          armed = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pixel content served by the external source for a given coordinate.
  function automatic logic [23:0] src_f(input logic [11:0] x, input logic [11:0] y);
    return {x[7:0], y[7:0] ^ salt, {4'h0, x[11:8]} ^ salt};
  endfunction

  function automatic logic [23:0] bar_rgb(input int x, input int ha);
    case ((x * 8) / ha)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(input rec_t p, input int ha);
    if (!p.req)          return 24'h000000;
    if (p.mode == 2'd0)  return src_f(p.x, p.y);
    if (p.mode == 2'd1)  return bar_rgb(int'(p.x), ha);
    return p.solid;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : cfg
    localparam int HS  = (gi == 0) ? 2 : (gi == 1) ? 3  : 136;
    localparam int HB  = (gi == 0) ? 2 : (gi == 1) ? 1  : 160;
    localparam int HA  = (gi == 0) ? 8 : (gi == 1) ? 16 : 1024;
    localparam int HF  = (gi == 0) ? 2 : (gi == 1) ? 2  : 24;
    localparam int VS  = (gi == 0) ? 1 : (gi == 1) ? 2  : 1;
    localparam int VB  = (gi == 0) ? 1 : (gi == 1) ? 1  : 1;
    localparam int VA  = (gi == 0) ? 4 : (gi == 1) ? 3  : 2;
    localparam int VF  = (gi == 0) ? 1 : (gi == 1) ? 2  : 1;
    localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 0  : 7;
    localparam int HP  = (gi == 1) ? 0 : 1;
    localparam int VP  = (gi == 1) ? 0 : 1;
    localparam int HT  = HS + HB + HA + HF;
    localparam int VT  = VS + VB + VA + VF;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;
    localparam bit HPB = (HP != 0);
    localparam bit VPB = (VP != 0);

    logic        pix_req, frame_start, po_de, po_h_sync, po_v_sync;
    logic [11:0] pix_x, pix_y;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [23:0] rgb_pixel;
    int          de_seen = 0;

    video_timing_gen #(
      .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
      .HS_POL(HP), .VS_POL(VP), .PIX_LAT(LAT), .CW(12)
    ) u_dut (
      .sclk        (sclk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .solid_rgb   (solid_rgb),
      .rgb_pixel   (rgb_pixel),
      .pix_req     (pix_req),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .po_vga_r    (vga_r),
      .po_vga_g    (vga_g),
      .po_vga_b    (vga_b),
      .po_de       (po_de),
      .po_h_sync   (po_h_sync),
      .po_v_sync   (po_v_sync)
    );

    // External pixel source: answers each request LAT cycles later, noise otherwise.
    logic [23:0] src_d [8];
    logic        src_v [8];
    always @(posedge sclk) begin
      src_v[0] <= pix_req;
      src_d[0] <= src_f(pix_x, pix_y);
      for (int k = 1; k < 8; k++) begin
        src_v[k] <= src_v[k-1];
        src_d[k] <= src_d[k-1];
      end
    end
    if (LAT == 0) begin : g_src_now
      assign rgb_pixel = pix_req ? src_f(pix_x, pix_y) : noise;
    end else begin : g_src_late
      assign rgb_pixel = src_v[LAT-1] ? src_d[LAT-1] : noise;
    end

    // Raster model: h/v position plus a history of what each past cycle should request.
    int          h = 0;
    int          v = 0;
    logic        live;
    logic [1:0]  m_mode;
    logic [23:0] m_solid;
    rec_t        cur;
    rec_t        hist [9];

    always_comb begin
      live      = en && !rst;
      cur       = '0;
      cur.req   = live && (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
      if (cur.req) begin
        cur.x = 12'(h - HA0);
        cur.y = 12'(v - VA0);
      end
      cur.hs    = live && (h < HS);
      cur.vs    = live && (v < VS);
      cur.mode  = m_mode;
      cur.solid = m_solid;
    end

    always @(posedge sclk) begin
      if (rst) begin
        for (int k = 0; k < 9; k++) hist[k] <= '0;
        m_mode  <= '0;
        m_solid <= '0;
      end else begin
        hist[0] <= cur;
        for (int k = 1; k < 9; k++) hist[k] <= hist[k-1];
        if (live && h == 0 && v == 0) begin
          m_mode  <= mode;
          m_solid <= solid_rgb;
        end
      end
      if (!live) begin
        h <= 0;
        v <= 0;
      end else if (h == HT - 1) begin
        h <= 0;
        v <= (v == VT - 1) ? 0 : v + 1;
      end else begin
        h <= h + 1;
      end
    end

    always @(negedge sclk) begin
      if (armed) begin
        check($sformatf("c%0d pix_req", gi), pix_req, hist[0].req);
        check($sformatf("c%0d pix_x", gi), pix_x, hist[0].x);
        check($sformatf("c%0d pix_y", gi), pix_y, hist[0].y);
        check($sformatf("c%0d frame_start", gi), frame_start, en && !rst && h == 0 && v == 0);
        check($sformatf("c%0d po_de", gi), po_de, hist[LAT+1].req);
        check($sformatf("c%0d hsync", gi), po_h_sync, hist[LAT+1].hs ? HPB : !HPB);
        check($sformatf("c%0d vsync", gi), po_v_sync, hist[LAT+1].vs ? VPB : !VPB);
        check($sformatf("c%0d rgb", gi), {vga_r, vga_g, vga_b}, exp_rgb(hist[LAT+1], HA));
        de_seen <= de_seen + int'(po_de);
      end
    end
  end

  initial begin
    int rst_cnt;
    int off_cnt;
    rst       = 1'b1;
    en        = 1'b0;
    mode      = 2'd1;
    solid_rgb = 24'h123456;
    noise     = 24'($urandom);
    salt      = 8'($urandom);
    rst_cnt   = 0;
    off_cnt   = 0;

    @(posedge sclk); #1;
    armed = 1'b1;
    repeat (2) begin
      @(posedge sclk); #1;
    end
    rst = 1'b0;
    en  = 1'b1;

    // Phase A: undisturbed frames, occasional mode/colour changes landing mid-frame.
    for (int c = 0; c < NCYC_A; c++) begin
      @(posedge sclk); #1;
      noise = 24'($urandom);
      if ($urandom_range(299, 0) == 0) begin
        mode      = 2'($urandom);
        solid_rgb = 24'($urandom);
      end
    end

    // Phase B: random enable drops and reset pulses on top of mode changes.
    for (int c = 0; c < NCYC_B; c++) begin
      @(posedge sclk); #1;
      noise = 24'($urandom);
      if (rst_cnt > 0) rst_cnt--;
      else if ($urandom_range(4999, 0) == 0) rst_cnt = $urandom_range(3, 1);
      rst = (rst_cnt > 0);
      if (off_cnt > 0) off_cnt--;
      else if ($urandom_range(1499, 0) == 0) off_cnt = $urandom_range(60, 1);
      en = (off_cnt == 0);
      if ($urandom_range(299, 0) == 0) begin
        mode      = 2'($urandom);
        solid_rgb = 24'($urandom);
      end
    end

    @(negedge sclk);
    check("c0 de_seen", cfg[0].de_seen > 0, 1);
    check("c1 de_seen", cfg[1].de_seen > 0, 1);
    check("c2 de_seen", cfg[2].de_seen > 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
